// File: rtl/coh_bus_sequencer.sv
// Serialises per-core coherence requests onto the shared snoop bus and merges snoop
// responses into one completion. Optional snoop-phase timeout: COH_SNOOP_TIMEOUT_EN.
module coh_bus_sequencer #(
    parameter int unsigned NumCores      = 4,
    parameter int unsigned AddrW         = 32,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [NumCores-1:0]       core_req_valid,
    input  logic [2*NumCores-1:0]     core_req_cmd,
    input  logic [AddrW*NumCores-1:0] core_req_addr,
    output logic [NumCores-1:0]       core_req_ready,
    output logic [NumCores-1:0]       arb_req,
    input  logic [NumCores-1:0]       arb_grant,
    output logic                      bus_valid,
    output logic [1:0]                bus_cmd,
    output logic [AddrW-1:0]          bus_addr,
    output logic [NumCores-1:0]       bus_src,
    input  logic [NumCores-1:0]       snoop_done,
    input  logic [NumCores-1:0]       snoop_shared,
    input  logic [NumCores-1:0]       snoop_dirty,
    output logic                      resp_valid,
    output logic [NumCores-1:0]       resp_dst,
    output logic                      resp_shared,
    output logic                      resp_dirty,
    output logic                      resp_err,
    input  logic                      resp_ready
);
    typedef enum logic [1:0] {IDLE, BCAST, SNOOP, RESP} state_e;
    localparam logic [1:0] CmdFlush = 2'b11;

    if (TimeoutCycles < 2) begin : g_timeout_param_check
        $error("TimeoutCycles must be at least 2");
    end

    state_e              state_q;
    logic [1:0]          cmd_q;
    logic [AddrW-1:0]    addr_q;
    logic [NumCores-1:0] src_q;
    logic [NumCores-1:0] done_q;
    logic                shared_q;
    logic                dirty_q;

    logic [1:0]          grant_cmd;
    logic [AddrW-1:0]    grant_addr;
    logic [NumCores-1:0] new_done;
    logic [NumCores-1:0] done_d;
    logic                shared_d;
    logic                dirty_d;
    logic                snoop_complete;

    // Grant is one-hot, so an OR of the masked per-core fields selects the winner.
    always_comb begin
        grant_cmd  = '0;
        grant_addr = '0;
        for (int i = 0; i < NumCores; i++) begin
            if (arb_grant[i]) begin
                grant_cmd  = grant_cmd | core_req_cmd[2*i +: 2];
                grant_addr = grant_addr | core_req_addr[AddrW*i +: AddrW];
            end
        end
    end

    // Only first responses from non-source cores contribute.
    assign new_done       = snoop_done & ~src_q & ~done_q;
    assign done_d         = done_q | new_done;
    assign shared_d       = shared_q | (|(snoop_shared & new_done));
    assign dirty_d        = dirty_q | (|(snoop_dirty & new_done));
    assign snoop_complete = &(done_d | src_q);

`ifdef COH_SNOOP_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    logic [CntW-1:0] cnt_q;
    logic            err_q;
    logic            timeout_hit;
    assign timeout_hit = (cnt_q == CntW'(TimeoutCycles - 1));
    assign resp_err    = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            addr_q   <= '0;
            src_q    <= '0;
            done_q   <= '0;
            shared_q <= 1'b0;
            dirty_q  <= 1'b0;
`ifdef COH_SNOOP_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|arb_grant) begin
                        cmd_q   <= grant_cmd;
                        addr_q  <= grant_addr;
                        src_q   <= arb_grant;
                        state_q <= BCAST;
                    end
                end
                BCAST: begin
                    done_q   <= '0;
                    shared_q <= 1'b0;
                    dirty_q  <= 1'b0;
`ifdef COH_SNOOP_TIMEOUT_EN
                    cnt_q    <= '0;
                    err_q    <= 1'b0;
`endif
                    state_q  <= (cmd_q == CmdFlush) ? RESP : SNOOP;
                end
                SNOOP: begin
                    done_q   <= done_d;
                    shared_q <= shared_d;
                    dirty_q  <= dirty_d;
`ifdef COH_SNOOP_TIMEOUT_EN
                    cnt_q    <= cnt_q + 1'b1;
                    if (!snoop_complete && timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end
`endif
                    if (snoop_complete) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Requests are exposed only in IDLE so the arbiter advances once per transaction.
    assign arb_req        = (rstN && state_q == IDLE) ? core_req_valid : '0;
    assign core_req_ready = (rstN && state_q == IDLE) ? arb_grant : '0;

    assign bus_valid   = (state_q == BCAST);
    assign bus_cmd     = cmd_q;
    assign bus_addr    = addr_q;
    assign bus_src     = src_q;
    assign resp_valid  = (state_q == RESP);
    assign resp_dst    = src_q;
    assign resp_shared = shared_q;
    assign resp_dirty  = dirty_q;
endmodule

// File: tb/tb_coh_bus_sequencer.sv
// Directed bench for coh_bus_sequencer with a reference round-robin arbiter.
module tb_coh_bus_sequencer;
    localparam int N  = 4;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rstN;
    logic [N-1:0]    core_req_valid;
    logic [2*N-1:0]  core_req_cmd;
    logic [AW*N-1:0] core_req_addr;
    logic [N-1:0]    core_req_ready;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_grant;
    logic            bus_valid;
    logic [1:0]      bus_cmd;
    logic [AW-1:0]   bus_addr;
    logic [N-1:0]    bus_src;
    logic [N-1:0]    snoop_done;
    logic [N-1:0]    snoop_shared;
    logic [N-1:0]    snoop_dirty;
    logic            resp_valid;
    logic [N-1:0]    resp_dst;
    logic            resp_shared;
    logic            resp_dirty;
    logic            resp_err;
    logic            resp_ready;

    int checks   = 0;
    int failures = 0;
    int last_grant = N - 1;
    logic arb_found;

    always #5 clk = ~clk;

    coh_bus_sequencer #(
        .NumCores(N), .AddrW(AW), .TimeoutCycles(8)
    ) dut (
        .clk(clk), .rstN(rstN),
        .core_req_valid(core_req_valid), .core_req_cmd(core_req_cmd),
        .core_req_addr(core_req_addr), .core_req_ready(core_req_ready),
        .arb_req(arb_req), .arb_grant(arb_grant),
        .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_src(bus_src),
        .snoop_done(snoop_done), .snoop_shared(snoop_shared), .snoop_dirty(snoop_dirty),
        .resp_valid(resp_valid), .resp_dst(resp_dst), .resp_shared(resp_shared),
        .resp_dirty(resp_dirty), .resp_err(resp_err), .resp_ready(resp_ready)
    );

    // Reference round-robin arbiter: search starts after the last granted core.
    always_comb begin
        arb_grant = '0;
        arb_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!arb_found && arb_req[(last_grant + k) % N]) begin
                arb_grant[(last_grant + k) % N] = 1'b1;
                arb_found = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (arb_grant[k]) last_grant <= k;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [1:0] cmd, input logic [AW-1:0] addr);
        core_req_cmd[2*c +: 2]    = cmd;
        core_req_addr[AW*c +: AW] = addr;
    endtask

    initial begin
        rstN = 1'b0;
        core_req_valid = 4'b1111;
        core_req_cmd = '0;
        core_req_addr = '0;
        snoop_done = '0;
        snoop_shared = '0;
        snoop_dirty = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 2'b00, 32'h10 + 32'h100 * i);

        // Reset state, with requests already pending
        tick();
        tick();
        chk("rst_arb_req", arb_req, 4'b0000);
        chk("rst_ready", core_req_ready, 4'b0000);
        chk("rst_bus_valid", bus_valid, 1'b0);
        chk("rst_bus_src", bus_src, 4'b0000);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        rstN = 1'b1;
        #1;

        // Fairness: all valid, instant snoopers, resp_ready high
        snoop_done = 4'b1111;
        resp_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            chk("rr_arb_req_idle", arb_req, 4'b1111);
            chk("rr_ready", core_req_ready, 4'b0001 << (t % 4));
            tick();
            chk("rr_bus_valid", bus_valid, 1'b1);
            chk("rr_bus_src", bus_src, 4'b0001 << (t % 4));
            chk("rr_bus_addr", bus_addr, 32'h10 + 32'h100 * (t % 4));
            chk("rr_arb_req_bcast", arb_req, 4'b0000);
            tick();
            chk("rr_snoop_bus_valid", bus_valid, 1'b0);
            chk("rr_arb_req_snoop", arb_req, 4'b0000);
            chk("rr_snoop_resp_valid", resp_valid, 1'b0);
            tick();
            chk("rr_resp_valid", resp_valid, 1'b1);
            chk("rr_resp_dst", resp_dst, 4'b0001 << (t % 4));
            chk("rr_arb_req_resp", arb_req, 4'b0000);
            if (t == 4) begin
                core_req_valid = '0;
                snoop_done = '0;
            end
            $display("txn rr %0d: core %0d granted", t, t % 4);
            tick();
        end
        resp_ready = 1'b0;
        #1;
        chk("rr_idle_after", resp_valid, 1'b0);

        // Single BusRd from core 2
        set_req(2, 2'b00, 32'h1000);
        core_req_valid = 4'b0100;
        #1;
        chk("rd_arb_req", arb_req, 4'b0100);
        chk("rd_ready", core_req_ready, 4'b0100);
        tick();
        core_req_valid = '0;
        #1;
        chk("rd_bus_valid", bus_valid, 1'b1);
        chk("rd_bus_src", bus_src, 4'b0100);
        chk("rd_bus_addr", bus_addr, 32'h1000);
        chk("rd_bus_cmd", bus_cmd, 2'b00);
        tick();
        snoop_done = 4'b1011;
        snoop_shared = 4'b0010;
        #1;
        chk("rd_snoop_no_resp", resp_valid, 1'b0);
        tick();
        snoop_done = '0;
        snoop_shared = '0;
        #1;
        chk("rd_resp_valid", resp_valid, 1'b1);
        chk("rd_resp_dst", resp_dst, 4'b0100);
        chk("rd_resp_shared", resp_shared, 1'b1);
        chk("rd_resp_dirty", resp_dirty, 1'b0);
        chk("rd_resp_err", resp_err, 1'b0);
        $display("txn rd: core 2 BusRd shared=%0d dirty=%0d", resp_shared, resp_dirty);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk("rd_resp_done", resp_valid, 1'b0);

        // Flush from core 0: no snoop phase
        set_req(0, 2'b11, 32'hDEAD0000);
        core_req_valid = 4'b0001;
        #1;
        chk("fl_ready", core_req_ready, 4'b0001);
        tick();
        core_req_valid = '0;
        #1;
        chk("fl_bus_valid", bus_valid, 1'b1);
        chk("fl_bus_cmd", bus_cmd, 2'b11);
        chk("fl_bus_addr", bus_addr, 32'hDEAD0000);
        tick();
        chk("fl_resp_valid", resp_valid, 1'b1);
        chk("fl_resp_dst", resp_dst, 4'b0001);
        chk("fl_resp_shared", resp_shared, 1'b0);
        chk("fl_resp_dirty", resp_dirty, 1'b0);
        $display("txn flush: core 0 completed without snoop");
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Out-of-order and duplicate done, BusRdX from core 3
        set_req(3, 2'b01, 32'h2000);
        core_req_valid = 4'b1000;
        #1;
        chk("oo_ready", core_req_ready, 4'b1000);
        tick();
        core_req_valid = '0;
        snoop_done = 4'b0100;
        snoop_shared = 4'b0100;
        #1;
        chk("oo_bus_valid", bus_valid, 1'b1);
        chk("oo_bus_cmd", bus_cmd, 2'b01);
        tick();
        snoop_done = 4'b0010;
        snoop_shared = '0;
        snoop_dirty = 4'b0010;
        #1;
        chk("oo_snoop1", resp_valid, 1'b0);
        tick();
        #1;
        chk("oo_snoop2_dup", resp_valid, 1'b0);
        tick();
        snoop_done = 4'b0001;
        snoop_dirty = '0;
        #1;
        chk("oo_snoop3", resp_valid, 1'b0);
        tick();
        snoop_done = 4'b1000;
        #1;
        chk("oo_snoop4_src", resp_valid, 1'b0);
        tick();
        snoop_done = 4'b0100;
        #1;
        chk("oo_snoop5_last", resp_valid, 1'b0);
        tick();
        snoop_done = '0;
        #1;
        chk("oo_resp_valid", resp_valid, 1'b1);
        chk("oo_resp_dst", resp_dst, 4'b1000);
        chk("oo_resp_dirty", resp_dirty, 1'b1);
        chk("oo_resp_shared", resp_shared, 1'b0);
        $display("txn ooo: core 3 BusRdX dirty=%0d", resp_dirty);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk("oo_single_resp_a", resp_valid, 1'b0);
        tick();
        chk("oo_single_resp_b", resp_valid, 1'b0);

        // Backpressure then reset during RESP
        set_req(0, 2'b00, 32'h3000);
        set_req(1, 2'b10, 32'h4000);
        core_req_valid = 4'b0011;
        #1;
        chk("bp_ready", core_req_ready, 4'b0001);
        tick();
        core_req_valid = 4'b0010;
        #1;
        chk("bp_arb_req_bcast", arb_req, 4'b0000);
        chk("bp_ready_bcast", core_req_ready, 4'b0000);
        tick();
        snoop_done = 4'b1110;
        snoop_shared = 4'b0100;
        snoop_dirty = 4'b1000;
        tick();
        snoop_done = '0;
        snoop_shared = '0;
        snoop_dirty = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_resp_valid", resp_valid, 1'b1);
            chk("bp_resp_dst", resp_dst, 4'b0001);
            chk("bp_resp_shared", resp_shared, 1'b1);
            chk("bp_resp_dirty", resp_dirty, 1'b1);
            tick();
        end
        rstN = 1'b0;
        #1;
        chk("rr_mid_resp_valid", resp_valid, 1'b0);
        chk("rr_mid_resp_dst", resp_dst, 4'b0000);
        chk("rr_mid_resp_shared", resp_shared, 1'b0);
        chk("rr_mid_resp_dirty", resp_dirty, 1'b0);
        chk("rr_mid_bus_src", bus_src, 4'b0000);
        chk("rr_mid_bus_valid", bus_valid, 1'b0);
        chk("rr_mid_arb_req", arb_req, 4'b0000);
        chk("rr_mid_ready", core_req_ready, 4'b0000);
        $display("txn bp: core 0 abandoned by reset");
        tick();
        rstN = 1'b1;
        #1;
        chk("rs_arb_req", arb_req, 4'b0010);
        chk("rs_ready", core_req_ready, 4'b0010);
        tick();
        core_req_valid = '0;
        #1;
        chk("rs_bus_src", bus_src, 4'b0010);
        chk("rs_bus_cmd", bus_cmd, 2'b10);
        chk("rs_bus_addr", bus_addr, 32'h4000);
        tick();
        snoop_done = 4'b1101;
        tick();
        snoop_done = '0;
        #1;
        chk("rs_resp_valid", resp_valid, 1'b1);
        chk("rs_resp_dst", resp_dst, 4'b0010);
        chk("rs_resp_shared", resp_shared, 1'b0);
        chk("rs_resp_dirty", resp_dirty, 1'b0);
        $display("txn rearb: core 1 BusUpgr completed after reset");
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk("rs_resp_done", resp_valid, 1'b0);

`ifdef COH_SNOOP_TIMEOUT_EN
        // Core 2 never answers: expect RESP after 8 SNOOP cycles with err
        set_req(0, 2'b00, 32'h5000);
        core_req_valid = 4'b0001;
        #1;
        chk("to_ready", core_req_ready, 4'b0001);
        tick();
        core_req_valid = '0;
        tick();
        snoop_done = 4'b1010;
        snoop_shared = 4'b0010;
        #1;
        chk("to_snoop0", resp_valid, 1'b0);
        for (int k = 1; k < 8; k++) begin
            tick();
            snoop_done = '0;
            snoop_shared = '0;
            #1;
            chk("to_snoop_wait", resp_valid, 1'b0);
        end
        tick();
        chk("to_resp_valid", resp_valid, 1'b1);
        chk("to_resp_err", resp_err, 1'b1);
        chk("to_resp_shared", resp_shared, 1'b1);
        chk("to_resp_dirty", resp_dirty, 1'b0);
        $display("txn timeout: core 0 err=%0d", resp_err);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coh_bus_sequencer.md
Name: coh_bus_sequencer

Overview:
- Downstream consumer of the round-robin arbiter grant in the snooping coherence fabric.
- Collects per-core coherence requests and presents them to the arbiter as a request vector.
- Captures the granted core's command and address, broadcasts it on the shared snoop bus, collects snoop responses from every other core, and returns a merged completion to the requester.
- Handles one bus transaction at a time.

Parameters:
- NumCores, 4, number of requesting cores; equals the arbiter's NumRequests.
- AddrW, 32, address width.
- TimeoutCycles, 64, snoop-phase cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rstN  in  1  asynchronous active-low reset
- core_req_valid  in  NumCores  per-core request valid; held until accepted
- core_req_cmd  in  2*NumCores  per-core cmd; core i at [2i+1:2i]; 00 BusRd, 01 BusRdX, 10 BusUpgr, 11 Flush
- core_req_addr  in  AddrW*NumCores  per-core address; core i at [AddrW*i +: AddrW]
- core_req_ready  out  NumCores  one-hot, one-cycle accept pulse
- arb_req  out  NumCores  request vector to the arbiter
- arb_grant  in  NumCores  one-hot grant from the arbiter, combinational from arb_req
- bus_valid  out  1  snoop broadcast strobe, one cycle
- bus_cmd  out  2  broadcast command
- bus_addr  out  AddrW  broadcast address
- bus_src  out  NumCores  one-hot source core; held valid BCAST through RESP
- snoop_done  in  NumCores  per-core snoop-complete pulse
- snoop_shared  in  NumCores  qualified by snoop_done; core holds the line
- snoop_dirty  in  NumCores  qualified by snoop_done; core supplied dirty data
- resp_valid  out  1  completion valid
- resp_dst  out  NumCores  one-hot requester, equal to bus_src
- resp_shared  out  1  OR of the shared bits from all snoopers
- resp_dirty  out  1  OR of the dirty bits from all snoopers
- resp_err  out  1  snoop timeout; constant 0 without the optional feature
- resp_ready  in  1  requester accepts the completion

Behaviour:
- Reset (rstN low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; captured cmd/addr/src, the done mask, the shared/dirty accumulators and the timeout counter are cleared.
  - Reset asserted mid-transaction abandons the transaction; no completion is issued.
- States: IDLE, BCAST, SNOOP, RESP.
- IDLE:
  - arb_req = core_req_valid. arb_req is 0 in every other state, so the arbiter's mask advances exactly once per transaction.
  - If arb_grant is nonzero:
    - Capture cmd/addr of the granted core and set src = arb_grant.
    - Pulse core_req_ready = arb_grant in the same cycle.
    - Next state is BCAST.
  - If arb_grant is 0, stay in IDLE.
- BCAST:
  - bus_valid = 1 for exactly one cycle, carrying the captured cmd/addr/src.
  - Clear the done mask and the accumulators.
  - If cmd is Flush, go to RESP with shared = 0 and dirty = 0; no snoop phase.
  - Otherwise go to SNOOP.
  - snoop_done is ignored in this cycle.
- SNOOP:
  - Each cycle, for every core i that is not src with snoop_done[i] = 1:
    - set done[i];
    - OR snoop_shared[i] into shared;
    - OR snoop_dirty[i] into dirty.
  - snoop_done from src, or from a core already marked done, is ignored; a repeated done does not re-accumulate.
  - Go to RESP when (done | src) is all ones, evaluated including the current cycle's snoop_done.
  - Minimum SNOOP duration is one cycle. With NumCores = 1, SNOOP exits after one cycle.
- RESP:
  - resp_valid = 1 with resp_dst = src and the accumulated flags.
  - Hold until resp_ready = 1, then go to IDLE on the next edge.
  - A new arbitration may occur in that following IDLE cycle.
  - Back-to-back throughput is therefore at best one transaction per 4 cycles: IDLE, BCAST, SNOOP, RESP.
- Stability:
  - core_req_valid deasserting before core_req_ready is a protocol violation; no recovery is defined.
  - Requests from non-granted cores remain pending and are not affected.

Optional Feature:
- Macro: COH_SNOOP_TIMEOUT_EN.
- Defined:
  - A counter clears on SNOOP entry and increments each SNOOP cycle.
  - If the counter reaches TimeoutCycles-1 without completion, go to RESP with resp_err = 1 and the partial shared/dirty flags.
  - Completion arriving on the same cycle as expiry takes priority: resp_err = 0.
- Undefined:
  - No counter is present; resp_err is tied to 0.
  - SNOOP waits indefinitely.

Test Plan:
- Single BusRd: core 2 valid, addr 0x1000, cmd 00; cores 0, 1 and 3 each pulse done one cycle after bus_valid, core 1 with shared = 1 -> core_req_ready = 0100, then bus_valid with bus_src = 0100, then resp_valid with resp_dst = 0100, resp_shared = 1, resp_dirty = 0.
- Fairness: all four cores valid continuously, snoopers answering immediately, resp_ready tied high -> grant order 0, 1, 2, 3, 0; arb_req nonzero only in IDLE cycles; 4 cycles per transaction.
- Flush: core 0 cmd 11 -> bus_valid, then RESP in the next cycle with resp_shared = 0 and resp_dirty = 0; snoop_done is never required.
- Out-of-order and duplicate done: core 3 BusRdX; core 1 pulses done with dirty = 1 twice, core 0 done, core 3 (src) done ignored, core 2 done last -> resp_dirty = 1, exactly one resp_valid, and RESP is entered the cycle after core 2's done.
- Backpressure and reset: hold resp_ready = 0 for 5 cycles -> resp_valid and all resp fields are stable; assert rstN = 0 during RESP -> all outputs 0 immediately, and after release core 1's pending request is re-arbitrated.
- Timeout (COH_SNOOP_TIMEOUT_EN, TimeoutCycles = 8): core 2 never sends done -> RESP after 8 SNOOP cycles with resp_err = 1 and partial flags.
